ring_counter_gen: RTL and testbench

- Parametrised one-hot ring / Johnson (twisted-ring) shift counter; successor to the fixed 16-bit rotate-left ring counter with a single tap.
- Adds run-time direction, synchronous load, a wrap pulse and a selectable tap.
- Optional self-correction of corrupted ring states.
- Used as a low-cost timing/sequencing source: phase strobes, divided pulses, round-robin selects.

---
 rtl/ring_counter_gen.sv | 90 +++++++++
 tb/tb_ring_counter_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_gen.sv
// Parametrised one-hot ring / Johnson shift counter with direction, load, wrap pulse and tap.
// Define RING_SELF_CORRECT_EN to restore INIT (and pulse err) on corrupted ring states.
module ring_counter_gen #(
  parameter int               WIDTH = 16,
  parameter int               TAP   = 9,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             count_pulse,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] shl, shr;
  logic             wrap_reg, wrap_next;
  logic             err_reg, err_next;
  logic             fb_left, fb_right;
  logic             invalid;

  // Johnson mode feeds back the inverted outgoing bit; ring mode feeds it back unchanged.
  if (MODE == 1) begin : g_johnson
    assign fb_left  = ~count_reg[WIDTH-1];
    assign fb_right = ~count_reg[0];
  end else begin : g_ring
    assign fb_left  = count_reg[WIDTH-1];
    assign fb_right = count_reg[0];
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == 0) begin : g_lsb
      assign shl[gi] = fb_left;
    end else begin : g_mid_l
      assign shl[gi] = count_reg[gi-1];
    end
    if (gi == WIDTH-1) begin : g_msb
      assign shr[gi] = fb_right;
    end else begin : g_mid_r
      assign shr[gi] = count_reg[gi+1];
    end
  end

`ifdef RING_SELF_CORRECT_EN
  assign invalid = (MODE == 0) && ($countones(count_reg) != 1);
`else
  assign invalid = 1'b0;
`endif

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    err_next   = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (enable) begin
      if (invalid) begin
        count_next = INIT;
        err_next   = 1'b1;
      end else begin
        count_next = dir ? shr : shl;
        wrap_next  = (count_next == INIT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= INIT;
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign count       = count_reg;
  assign count_pulse = count_reg[TAP];
  assign wrap        = wrap_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Testbench for ring_counter_gen: default ring instance plus a 4-bit Johnson instance,
// directed scenarios followed by randomized stimulus against a shift-arithmetic model.
module tb_ring_counter_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, dir_a, load_a;
  logic [15:0] lv_a, cnt_a;
  logic        cp_a, wrap_a, err_a;
  logic        en_b, dir_b, load_b;
  logic [3:0]  lv_b, cnt_b;
  logic        cp_b, wrap_b, err_b;

  int checks = 0;
  int passed = 0;

  ring_counter_gen dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .dir(dir_a), .load(load_a),
    .load_val(lv_a), .count(cnt_a), .count_pulse(cp_a), .wrap(wrap_a), .err(err_a)
  );

  ring_counter_gen #(.WIDTH(4), .TAP(2), .MODE(1), .INIT(4'b0001)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .dir(dir_b), .load(load_b),
    .load_val(lv_b), .count(cnt_b), .count_pulse(cp_b), .wrap(wrap_b), .err(err_b)
  );

  function automatic logic [15:0] ring_step(input logic [15:0] c, input logic d);
    return d ? ((c >> 1) | (c << 15)) : ((c << 1) | (c >> 15));
  endfunction

  function automatic logic [3:0] johnson_step(input logic [3:0] c, input logic d);
    if (d) return (c >> 1) | ((((c & 4'd1) ^ 4'd1)) << 3);
    return ((c << 1) | ((c >> 3) ^ 4'd1)) & 4'hF;
  endfunction

  task automatic tick(input string name);
    @(posedge clk);
    #1;
    $display("txn %-10s a: count=%04h pulse=%0d wrap=%0d err=%0d | b: count=%b wrap=%0d err=%0d",
             name, cnt_a, cp_a, wrap_a, err_a, cnt_b, wrap_b, err_b);
  endtask

  task automatic idle_all();
    en_a = 0; dir_a = 0; load_a = 0; lv_a = '0;
    en_b = 0; dir_b = 0; load_b = 0; lv_b = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    #12;
    checks++;
    if ({cnt_a, cp_a, wrap_a, err_a} !== {16'h0001, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_a: got count=%04h pulse=%0d wrap=%0d err=%0d, want 0001/0/0/0",
               cnt_a, cp_a, wrap_a, err_a);
    else passed++;
    checks++;
    if ({cnt_b, wrap_b, err_b} !== {4'b0001, 1'b0, 1'b0})
      $display("FAIL reset_b: got count=%b wrap=%0d err=%0d, want 0001/0/0", cnt_b, wrap_b, err_b);
    else passed++;
    rst_n = 1;
    #2;
  endtask

  task automatic test_ring_left();
    logic [15:0] exp;
    en_a = 1; dir_a = 0;
    for (int k = 1; k <= 16; k++) begin
      tick("ring_left");
      exp = 16'(1 << (k % 16));
      checks++;
      if ({cnt_a, cp_a, wrap_a} !== {exp, (exp == 16'h0200), (k == 16)})
        $display("FAIL ring_left step %0d: got count=%04h pulse=%0d wrap=%0d, want %04h/%0d/%0d",
                 k, cnt_a, cp_a, wrap_a, exp, (exp == 16'h0200), (k == 16));
      else passed++;
    end
    en_a = 0;
  endtask

  task automatic test_dir_reverse();
    en_a = 1; dir_a = 1;
    tick("dir_right");
    checks++;
    if ({cnt_a, wrap_a} !== {16'h8000, 1'b0})
      $display("FAIL dir_right: got count=%04h wrap=%0d, want 8000/0", cnt_a, wrap_a);
    else passed++;
    dir_a = 0;
    tick("dir_left");
    checks++;
    if ({cnt_a, wrap_a} !== {16'h0001, 1'b1})
      $display("FAIL dir_left: got count=%04h wrap=%0d, want 0001/1", cnt_a, wrap_a);
    else passed++;
    en_a = 0;
    tick("hold_init");
    checks++;
    if ({cnt_a, wrap_a} !== {16'h0001, 1'b0})
      $display("FAIL hold_init: got count=%04h wrap=%0d, want 0001/0", cnt_a, wrap_a);
    else passed++;
  endtask

  task automatic test_johnson();
    logic [3:0] seq [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    en_b = 1; dir_b = 0;
    for (int k = 0; k < 8; k++) begin
      tick("johnson");
      checks++;
      if ({cnt_b, wrap_b, err_b} !== {seq[k], (k == 7), 1'b0})
        $display("FAIL johnson step %0d: got count=%b wrap=%0d err=%0d, want %b/%0d/0",
                 k + 1, cnt_b, wrap_b, err_b, seq[k], (k == 7));
      else passed++;
    end
    en_b = 0;
  endtask

  task automatic test_load_priority();
    load_a = 1; lv_a = 16'h0400;
    tick("load_0400");
    load_a = 1; en_a = 1; lv_a = 16'h0001;
    tick("load_init");
    checks++;
    if ({cnt_a, wrap_a} !== {16'h0001, 1'b0})
      $display("FAIL load_priority: got count=%04h wrap=%0d, want 0001/0", cnt_a, wrap_a);
    else passed++;
    load_a = 0;
    tick("step_after");
    checks++;
    if ({cnt_a, wrap_a} !== {16'h0002, 1'b0})
      $display("FAIL step_after_load: got count=%04h wrap=%0d, want 0002/0", cnt_a, wrap_a);
    else passed++;
    en_a = 0;
  endtask

  task automatic test_self_correct();
    logic [15:0] exp_cnt;
    logic        exp_err;
`ifdef RING_SELF_CORRECT_EN
    exp_cnt = 16'h0001; exp_err = 1'b1;
`else
    exp_cnt = 16'h0006; exp_err = 1'b0;
`endif
    load_a = 1; lv_a = 16'h0003;
    tick("load_0003");
    load_a = 0; en_a = 1; dir_a = 0;
    tick("corrupt");
    checks++;
    if ({cnt_a, wrap_a, err_a} !== {exp_cnt, 1'b0, exp_err})
      $display("FAIL self_correct: got count=%04h wrap=%0d err=%0d, want %04h/0/%0d",
               cnt_a, wrap_a, err_a, exp_cnt, exp_err);
    else passed++;
    en_a = 0;
    tick("corrupt_hold");
    checks++;
    if (err_a !== 1'b0)
      $display("FAIL err_one_cycle: got err=%0d, want 0", err_a);
    else passed++;
  endtask

  task automatic test_async_reset();
    load_a = 1; lv_a = 16'h0080;
    tick("load_0080");
    load_a = 0;
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({cnt_a, wrap_a, err_a} !== {16'h0001, 1'b0, 1'b0})
      $display("FAIL async_reset: got count=%04h wrap=%0d err=%0d, want 0001/0/0", cnt_a, wrap_a, err_a);
    else passed++;
    #1;
    rst_n = 1;
    en_a = 1; dir_a = 0;
    tick("post_reset");
    checks++;
    if ({cnt_a, wrap_a} !== {16'h0002, 1'b0})
      $display("FAIL post_reset_step: got count=%04h wrap=%0d, want 0002/0", cnt_a, wrap_a);
    else passed++;
    en_a = 0;
  endtask

  task automatic test_random();
    logic [15:0] m_a, nxt_a;
    logic [3:0]  m_b, nxt_b;
    logic        w_a, e_a, w_b;
    m_a = cnt_a;
    m_b = cnt_b;
    for (int i = 0; i < 200; i++) begin
      load_a = ($urandom_range(7, 0) == 0);
      en_a   = ($urandom_range(3, 0) != 0);
      dir_a  = 1'($urandom);
      lv_a   = ($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'(16'd1 << $urandom_range(15, 0));
      load_b = ($urandom_range(7, 0) == 0);
      en_b   = ($urandom_range(3, 0) != 0);
      dir_b  = 1'($urandom);
      lv_b   = 4'($urandom);
      w_a = 0; e_a = 0; w_b = 0;
      nxt_a = m_a;
      if (load_a) nxt_a = lv_a;
      else if (en_a) begin
`ifdef RING_SELF_CORRECT_EN
        if ($countones(m_a) != 1) begin nxt_a = 16'h0001; e_a = 1; end
        else begin nxt_a = ring_step(m_a, dir_a); w_a = (nxt_a == 16'h0001); end
`else
        nxt_a = ring_step(m_a, dir_a); w_a = (nxt_a == 16'h0001);
`endif
      end
      nxt_b = m_b;
      if (load_b) nxt_b = lv_b;
      else if (en_b) begin nxt_b = johnson_step(m_b, dir_b); w_b = (nxt_b == 4'b0001); end
      tick("random");
      m_a = nxt_a;
      m_b = nxt_b;
      checks++;
      if ({cnt_a, cp_a, wrap_a, err_a} !== {m_a, m_a[9], w_a, e_a})
        $display("FAIL random_a %0d: got count=%04h pulse=%0d wrap=%0d err=%0d, want %04h/%0d/%0d/%0d",
                 i, cnt_a, cp_a, wrap_a, err_a, m_a, m_a[9], w_a, e_a);
      else passed++;
      checks++;
      if ({cnt_b, cp_b, wrap_b, err_b} !== {m_b, m_b[2], w_b, 1'b0})
        $display("FAIL random_b %0d: got count=%b pulse=%0d wrap=%0d err=%0d, want %b/%0d/%0d/0",
                 i, cnt_b, cp_b, wrap_b, err_b, m_b, m_b[2], w_b);
      else passed++;
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_ring_left();
    test_dir_reverse();
    test_johnson();
    test_load_priority();
    test_self_correct();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
